// File: rtl/gray_expand.sv
// Grayscale-to-RGB expander: pops 8-bit pixels from an FWFT FIFO and pushes {g,g,g}
// to the output FIFO one cycle later, tracking frame position and flagging line/frame ends.
module gray_expand #(
  parameter int FIFO_DWIDTH_IN  = 8,
  parameter int FIFO_DWIDTH_OUT = 24,
  parameter int IMG_WIDTH       = 720,
  parameter int IMG_HEIGHT      = 540
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       fifo_in_rd_en,
  input  logic [FIFO_DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                       fifo_in_empty,
  output logic                       fifo_out_wr_en,
  output logic [FIFO_DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                       fifo_out_full,
  output logic                       line_done,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic xfer;
  logic last_col;
  logic last_row;
  logic last_pix;

  // NOTE: the pop strobe is gated by reset so a held reset never drains the input FIFO.
  assign xfer          = reset && !fifo_in_empty && !fifo_out_full;
  assign fifo_in_rd_en = xfer;

  assign last_col = (col == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));
  assign last_pix = last_col && last_row;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= S_IDLE;
      col            <= '0;
      row            <= '0;
      fifo_out_wr_en <= 1'b0;
      fifo_out_din   <= '0;
      line_done      <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      fifo_out_wr_en <= xfer;
      line_done      <= xfer && last_col;
      frame_done     <= xfer && last_pix;
      // Busy stays high through the frame_done write, hence it looks at the old state.
      busy           <= (state == S_ACTIVE) || (xfer && !last_pix);

      if (xfer) begin
        fifo_out_din <= {3{fifo_in_dout}};

        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        case (state)
          S_IDLE:   if (!last_pix) state <= S_ACTIVE;
          S_ACTIVE: if (last_pix)  state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_expand.sv
// Directed bench for gray_expand: a 4x2 frame instance plus a 1x1 instance sharing
// the same input stimulus, covering reset, stalls, line/frame flags and a random stream.
module tb_gray_expand;

  localparam int W = 4;
  localparam int H = 2;

  logic        clock;
  logic        reset;
  logic        fifo_in_empty;
  logic        fifo_out_full;
  logic [7:0]  fifo_in_dout;

  logic        rd_en, wr_en, ld, fd, bsy;
  logic [23:0] din;
  logic        rd_en1, wr_en1, ld1, fd1, bsy1;
  logic [23:0] din1;

  logic [27:0] obs, obs1, exp_v;
  int          checks   = 0;
  int          failures = 0;

  gray_expand #(.FIFO_DWIDTH_IN(8), .FIFO_DWIDTH_OUT(24), .IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (wr_en),
    .fifo_out_din   (din),
    .fifo_out_full  (fifo_out_full),
    .line_done      (ld),
    .frame_done     (fd),
    .busy           (bsy)
  );

  gray_expand #(.FIFO_DWIDTH_IN(8), .FIFO_DWIDTH_OUT(24), .IMG_WIDTH(1), .IMG_HEIGHT(1)) u_one (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (rd_en1),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (wr_en1),
    .fifo_out_din   (din1),
    .fifo_out_full  (fifo_out_full),
    .line_done      (ld1),
    .frame_done     (fd1),
    .busy           (bsy1)
  );

  assign obs  = {wr_en,  din,  ld,  fd,  bsy};
  assign obs1 = {wr_en1, din1, ld1, fd1, bsy1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    fifo_in_empty = 1'b1;
    fifo_out_full = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    fifo_in_empty = 1'b0;
    fifo_out_full = 1'b0;
    fifo_in_dout  = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({rd_en, obs} !== 29'h0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got rd=%b obs=%h want rd=0 obs=0", i, rd_en, obs);
      end
      checks++;
      if ({rd_en1, obs1} !== 29'h0) begin
        failures++;
        $display("FAIL reset_outputs_1x1 cycle %0d: got rd=%b obs=%h want 0", i, rd_en1, obs1);
      end
    end
    fifo_in_empty = 1'b1;
    reset         = 1'b1;
  endtask

  task automatic test_single_pixel();
    fifo_in_dout  = 8'h5A;
    fifo_in_empty = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b1) begin
      failures++;
      $display("FAIL single_rd_en: got %b want 1", rd_en);
    end
    step();
    fifo_in_empty = 1'b1;
    exp_v = {1'b1, 24'h5A5A5A, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL single_write: got %h want %h", obs, exp_v);
    end
    exp_v = {1'b1, 24'h5A5A5A, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs1 !== exp_v) begin
      failures++;
      $display("FAIL single_write_1x1: got %h want %h", obs1, exp_v);
    end
    step();
    exp_v = {1'b0, 24'h5A5A5A, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL single_idle_after: got %h want %h", obs, exp_v);
    end
    exp_v = {1'b0, 24'h5A5A5A, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs1 !== exp_v) begin
      failures++;
      $display("FAIL single_idle_after_1x1: got %h want %h", obs1, exp_v);
    end
  endtask

  task automatic test_full_stall();
    fifo_in_dout  = 8'hC3;
    fifo_in_empty = 1'b0;
    fifo_out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
        failures++;
        $display("FAIL full_stall cycle %0d: got rd=%b wr=%b want rd=0 wr=0", i, rd_en, wr_en);
      end
    end
    fifo_out_full = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b1) begin
      failures++;
      $display("FAIL full_release_rd_en: got %b want 1", rd_en);
    end
    step();
    fifo_in_empty = 1'b1;
    checks++;
    if (wr_en !== 1'b1 || din !== 24'hC3C3C3) begin
      failures++;
      $display("FAIL full_resume_write: got wr=%b din=%h want wr=1 din=c3c3c3", wr_en, din);
    end
  endtask

  task automatic test_frame();
    logic [7:0] p;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      p             = 8'(i);
      fifo_in_dout  = p;
      fifo_in_empty = 1'b0;
      step();
      exp_v = {1'b1, {3{p}}, (i % 4 == 3), (i == 7), 1'b1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL frame_write %0d: got %h want %h", i, obs, exp_v);
      end
      exp_v = {1'b1, {3{p}}, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs1 !== exp_v) begin
        failures++;
        $display("FAIL frame_write_1x1 %0d: got %h want %h", i, obs1, exp_v);
      end
    end
    fifo_in_empty = 1'b1;
    step();
    exp_v = {1'b0, 24'h070707, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL frame_end_idle: got %h want %h", obs, exp_v);
    end
    for (int i = 8; i < 12; i++) begin
      p             = 8'(i);
      fifo_in_dout  = p;
      fifo_in_empty = 1'b0;
      step();
      exp_v = {1'b1, {3{p}}, (i == 11), 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL next_frame_write %0d: got %h want %h", i, obs, exp_v);
      end
    end
    fifo_in_empty = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] p;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fifo_in_dout  = 8'h10 + 8'(i);
      fifo_in_empty = 1'b0;
      step();
    end
    reset        = 1'b0;
    fifo_in_dout = 8'h13;
    #1;
    checks++;
    if (rd_en !== 1'b0) begin
      failures++;
      $display("FAIL midreset_rd_en: got %b want 0", rd_en);
    end
    step();
    checks++;
    if (obs !== 28'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h want 0", obs);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p            = 8'h10 + 8'(i);
      fifo_in_dout = p;
      step();
      exp_v = {1'b1, {3{p}}, (p == 8'h13 || p == 8'h17), (p == 8'h17), 1'b1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL midreset_stream %h: got %h want %h", p, obs, exp_v);
      end
    end
    fifo_in_empty = 1'b1;
    step();
  endtask

  task automatic test_random_stream();
    logic [7:0] pix [1000];
    int  src, dst, mcol, mrow;
    logic e, f, x;
    logic [2:0] exp_flags;
    do_reset();
    for (int i = 0; i < 1000; i++) pix[i] = 8'($urandom_range(0, 255));
    src  = 0;
    dst  = 0;
    mcol = 0;
    mrow = 0;
    for (int cyc = 0; cyc < 6000 && dst < 1000; cyc++) begin
      e = (src >= 1000) || ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 3) == 0);
      fifo_in_empty = e;
      fifo_out_full = f;
      fifo_in_dout  = (src < 1000) ? pix[src] : 8'h00;
      x = !e && !f;
      #1;
      checks++;
      if (rd_en !== x) begin
        failures++;
        $display("FAIL rand_rd_en cycle %0d: got %b want %b", cyc, rd_en, x);
      end
      step();
      checks++;
      if (wr_en !== x) begin
        failures++;
        $display("FAIL rand_wr_en cycle %0d: got %b want %b", cyc, wr_en, x);
      end
      if (wr_en === 1'b1) begin
        checks++;
        if (din !== {3{pix[dst]}}) begin
          failures++;
          $display("FAIL rand_data %0d: got %h want %h", dst, din, {3{pix[dst]}});
        end
        exp_flags = {(mcol == W - 1), (mcol == W - 1 && mrow == H - 1), 1'b1};
        checks++;
        if ({ld, fd, wr_en1} !== exp_flags || {ld1, fd1, bsy1} !== 3'b110) begin
          failures++;
          $display("FAIL rand_flags %0d: got ld=%b fd=%b ld1=%b fd1=%b bsy1=%b want %b/110",
                   dst, ld, fd, ld1, fd1, bsy1, exp_flags);
        end
        if (mcol == W - 1) begin
          mcol = 0;
          mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
        dst++;
      end
      if (x) src++;
    end
    fifo_in_empty = 1'b1;
    fifo_out_full = 1'b0;
    checks++;
    if (dst != 1000) begin
      failures++;
      $display("FAIL rand_count: got %0d writes want 1000 (cycle budget)", dst);
    end
  endtask

  initial begin
    reset         = 1'b0;
    fifo_in_empty = 1'b1;
    fifo_out_full = 1'b0;
    fifo_in_dout  = 8'h00;
    test_reset();
    test_single_pixel();
    test_full_stall();
    test_frame();
    test_reset_mid_frame();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
